// File: rtl/multiword_adder_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : multiword_adder_sequencer
// Description : Multi-cycle add/subtract of DATA_WIDTH-bit operands using one
//               shared CHUNK_WIDTH adder, least significant chunk first. The
//               inter-chunk carry travels only through a register. Produces
//               result, carry-out (no-borrow for subtraction) and signed
//               overflow behind valid/ready handshakes on both sides.
//               DATA_WIDTH must be an integer multiple of CHUNK_WIDTH.
// Revision    : 1.0 - initial release
// ============================================================================
module multiword_adder_sequencer #(
    parameter int DATA_WIDTH  = 32,
    parameter int CHUNK_WIDTH = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  valid_i,
    output logic                  ready_o,
    input  logic [DATA_WIDTH-1:0] operand_A_i,
    input  logic [DATA_WIDTH-1:0] operand_B_i,
    input  logic                  subtract_i,
    input  logic                  carry_i,
    output logic [DATA_WIDTH-1:0] result_o,
    output logic                  carry_o,
    output logic                  overflow_o,
    output logic                  valid_o,
    input  logic                  ready_i
);

    localparam int NUM_CHUNKS = DATA_WIDTH / CHUNK_WIDTH;
    localparam int CNT_WIDTH  = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;

    localparam logic [CNT_WIDTH-1:0] c_last_cnt = CNT_WIDTH'(NUM_CHUNKS - 1);

    localparam logic [1:0] c_st_idle    = 2'd0;
    localparam logic [1:0] c_st_compute = 2'd1;
    localparam logic [1:0] c_st_done    = 2'd2;

    logic [1:0]            r_state;
    logic [1:0]            w_next_state;

    // Captured operands; r_b already holds ~B for subtraction.
    logic [DATA_WIDTH-1:0] r_a;
    logic [DATA_WIDTH-1:0] r_b;
    logic                  r_carry;
    logic [CNT_WIDTH-1:0]  r_cnt;

    logic [DATA_WIDTH-1:0] r_result;
    logic                  r_carry_out;
    logic                  r_overflow;

    logic [CHUNK_WIDTH-1:0] w_a_chunks [NUM_CHUNKS];
    logic [CHUNK_WIDTH-1:0] w_b_chunks [NUM_CHUNKS];

    logic [CHUNK_WIDTH-1:0] w_adder_a;
    logic [CHUNK_WIDTH-1:0] w_adder_b;
    logic [CHUNK_WIDTH-1:0] w_adder_sum;
    logic                   w_adder_cout;
    logic                   w_last;
    logic                   w_overflow;

    // Split the operand registers into chunk slices for the chunk selector.
    for (genvar k = 0; k < NUM_CHUNKS; k++) begin : g_chunk
        assign w_a_chunks[k] = r_a[k*CHUNK_WIDTH +: CHUNK_WIDTH];
        assign w_b_chunks[k] = r_b[k*CHUNK_WIDTH +: CHUNK_WIDTH];
    end

    // Shared chunk adder: the carry-in always comes from the carry register,
    // so there is no combinational carry path between chunks.
    assign w_adder_a = w_a_chunks[r_cnt];
    assign w_adder_b = w_b_chunks[r_cnt];
    assign {w_adder_cout, w_adder_sum} = {1'b0, w_adder_a} + {1'b0, w_adder_b}
                                       + {{CHUNK_WIDTH{1'b0}}, r_carry};

    assign w_last = (r_cnt == c_last_cnt);

    // Operands of equal sign producing a sum of the other sign overflow.
    assign w_overflow = (r_a[DATA_WIDTH-1] == r_b[DATA_WIDTH-1])
                     && (w_adder_sum[CHUNK_WIDTH-1] != r_a[DATA_WIDTH-1]);

    // State register with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode: accept in IDLE, walk chunks, hold in DONE until taken.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_st_idle:    if (valid_i) w_next_state = c_st_compute;
            c_st_compute: if (w_last)  w_next_state = c_st_done;
            c_st_done:    if (ready_i) w_next_state = c_st_idle;
            default:      w_next_state = c_st_idle;
        endcase
    end

    // Handshake outputs are decoded from the registered state only.
    always_comb begin
        ready_o = 1'b0;
        valid_o = 1'b0;
        case (r_state)
            c_st_idle: ready_o = 1'b1;
            c_st_done: valid_o = 1'b1;
            default: begin
                ready_o = 1'b0;
                valid_o = 1'b0;
            end
        endcase
    end

    // Datapath: operand capture on acceptance, one chunk per COMPUTE cycle.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            r_a         <= '0;
            r_b         <= '0;
            r_carry     <= 1'b0;
            r_cnt       <= '0;
            r_result    <= '0;
            r_carry_out <= 1'b0;
            r_overflow  <= 1'b0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (valid_i) begin
                        r_a     <= operand_A_i;
                        r_b     <= subtract_i ? ~operand_B_i : operand_B_i;
                        r_carry <= subtract_i ? 1'b1 : carry_i;
                        r_cnt   <= '0;
                    end
                end
                c_st_compute: begin
                    for (int k = 0; k < NUM_CHUNKS; k++) begin
                        if (r_cnt == CNT_WIDTH'(k)) begin
                            r_result[k*CHUNK_WIDTH +: CHUNK_WIDTH] <= w_adder_sum;
                        end
                    end
                    r_carry <= w_adder_cout;
                    if (w_last) begin
                        r_cnt       <= '0;
                        r_carry_out <= w_adder_cout;
                        r_overflow  <= w_overflow;
                    end else begin
                        r_cnt <= r_cnt + CNT_WIDTH'(1);
                    end
                end
                default: begin
                    r_cnt <= r_cnt;
                end
            endcase
        end
    end

    assign result_o   = r_result;
    assign carry_o    = r_carry_out;
    assign overflow_o = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_multiword_adder_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_multiword_adder_sequencer
// Description : Self-checking bench for multiword_adder_sequencer
//               (DATA_WIDTH 32, CHUNK_WIDTH 8): directed vector table,
//               backpressure and mid-operation reset sequences, and a random
//               regression against an arithmetic reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_multiword_adder_sequencer;

    logic        clk_i = 1'b0;
    logic        rst_n_i;
    logic        valid_i;
    logic        ready_o;
    logic [31:0] operand_A_i;
    logic [31:0] operand_B_i;
    logic        subtract_i;
    logic        carry_i;
    logic [31:0] result_o;
    logic        carry_o;
    logic        overflow_o;
    logic        valid_o;
    logic        ready_i;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        sub;
        logic        cin;
        logic [31:0] res;
        logic        c;
        logic        ovf;
    } vec_t;

    vec_t vecs [8];

    multiword_adder_sequencer #(
        .DATA_WIDTH (32),
        .CHUNK_WIDTH(8)
    ) dut (
        .clk_i      (clk_i),
        .rst_n_i    (rst_n_i),
        .valid_i    (valid_i),
        .ready_o    (ready_o),
        .operand_A_i(operand_A_i),
        .operand_B_i(operand_B_i),
        .subtract_i (subtract_i),
        .carry_i    (carry_i),
        .result_o   (result_o),
        .carry_o    (carry_o),
        .overflow_o (overflow_o),
        .valid_o    (valid_o),
        .ready_i    (ready_i)
    );

    // Free-running clock.
    always #5 clk_i = ~clk_i;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: plain integer arithmetic on the operands.
    function automatic void model(input logic [31:0] a, input logic [31:0] b,
                                  input logic sub, input logic cin,
                                  output logic [31:0] r, output logic c, output logic o);
        longint unsigned t;
        longint          sa;
        longint          sb;
        longint          s;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (sub) begin
            r = a - b;
            c = (a >= b);
            s = sa - sb;
        end else begin
            t = longint'(a) + longint'(b) + (cin ? 64'd1 : 64'd0);
            r = t[31:0];
            c = t[32];
            s = sa + sb + (cin ? 64'sd1 : 64'sd0);
        end
        o = (s > 64'sd2147483647) || (s < -64'sd2147483648);
    endfunction

    // Present one request and return at the negedge after acceptance; the
    // operand inputs are then scrambled to show they are not used any more.
    task automatic send(input logic [31:0] a, input logic [31:0] b,
                        input logic sub, input logic cin);
        int w;
        w = 0;
        while (!ready_o && w < 50) begin
            @(negedge clk_i);
            w++;
        end
        if (!ready_o) check("accept_timeout", 64'(ready_o), 64'd1);
        operand_A_i = a;
        operand_B_i = b;
        subtract_i  = sub;
        carry_i     = cin;
        valid_i     = 1'b1;
        @(posedge clk_i);
        @(negedge clk_i);
        valid_i     = 1'b0;
        operand_A_i = $urandom;
        operand_B_i = $urandom;
        subtract_i  = 1'($urandom_range(0, 1));
        carry_i     = 1'($urandom_range(0, 1));
    endtask

    // Count rising edges from acceptance until valid_o is seen (bounded).
    task automatic collect(output int lat);
        lat = 0;
        while (!valid_o && lat < 20) begin
            @(posedge clk_i);
            lat++;
            @(negedge clk_i);
        end
    endtask

    // Hold the result for 'hold' cycles, then take it.
    task automatic release_result(input int hold);
        ready_i = 1'b0;
        repeat (hold) @(negedge clk_i);
        ready_i = 1'b1;
        @(negedge clk_i);
        ready_i = 1'b0;
    endtask

    task automatic run_op(input string name, input logic [31:0] a, input logic [31:0] b,
                          input logic sub, input logic cin,
                          input logic [31:0] er, input logic ec, input logic eo, input int hold);
        int lat;
        send(a, b, sub, cin);
        collect(lat);
        check({name, "_latency"}, 64'(lat), 64'd4);
        check({name, "_result"}, 64'(result_o), 64'(er));
        check({name, "_carry"}, 64'(carry_o), 64'(ec));
        check({name, "_overflow"}, 64'(overflow_o), 64'(eo));
        release_result(hold);
    endtask

    initial begin
        logic [31:0] ra;
        logic [31:0] rb;
        logic        rs;
        logic        rc;
        logic [31:0] er;
        logic        ec;
        logic        eo;
        int          lat;

        vecs[0] = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0};
        vecs[1] = '{32'h0000_0005, 32'h0000_0007, 1'b1, 1'b0, 32'hFFFF_FFFE, 1'b0, 1'b0};
        vecs[2] = '{32'h0000_0007, 32'h0000_0005, 1'b1, 1'b0, 32'h0000_0002, 1'b1, 1'b0};
        vecs[3] = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1};
        vecs[4] = '{32'h8000_0000, 32'h0000_0001, 1'b1, 1'b0, 32'h7FFF_FFFF, 1'b1, 1'b1};
        vecs[5] = '{32'h1234_5678, 32'h0F0F_0F0F, 1'b0, 1'b1, 32'h2143_6588, 1'b0, 1'b0};
        vecs[6] = '{32'h0000_0000, 32'h0000_0000, 1'b1, 1'b1, 32'h0000_0000, 1'b1, 1'b0};
        vecs[7] = '{32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b1};

        rst_n_i     = 1'b0;
        valid_i     = 1'b0;
        ready_i     = 1'b0;
        operand_A_i = '0;
        operand_B_i = '0;
        subtract_i  = 1'b0;
        carry_i     = 1'b0;
        repeat (2) @(negedge clk_i);
        check("reset_ready", 64'(ready_o), 64'd1);
        check("reset_valid", 64'(valid_o), 64'd0);
        check("reset_result", 64'(result_o), 64'd0);
        check("reset_carry", 64'(carry_o), 64'd0);
        check("reset_overflow", 64'(overflow_o), 64'd0);
        rst_n_i = 1'b1;
        @(negedge clk_i);

        // Directed vector table.
        for (int i = 0; i < 8; i++) begin
            run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].sub, vecs[i].cin,
                   vecs[i].res, vecs[i].c, vecs[i].ovf, i % 3);
        end

        // Backpressure: result held while a new request waits outside.
        send(32'd1, 32'd2, 1'b0, 1'b0);
        collect(lat);
        check("bp_first_result", 64'(result_o), 64'd3);
        ready_i     = 1'b0;
        valid_i     = 1'b1;
        operand_A_i = 32'h10;
        operand_B_i = 32'h20;
        subtract_i  = 1'b0;
        carry_i     = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i);
            check("bp_hold_valid", 64'(valid_o), 64'd1);
            check("bp_hold_result", 64'(result_o), 64'd3);
            check("bp_hold_ready", 64'(ready_o), 64'd0);
        end
        ready_i = 1'b1;
        @(negedge clk_i);
        check("bp_idle_ready", 64'(ready_o), 64'd1);
        check("bp_idle_valid", 64'(valid_o), 64'd0);
        ready_i = 1'b0;
        @(negedge clk_i);
        check("bp_accepted", 64'(ready_o), 64'd0);
        valid_i     = 1'b0;
        operand_A_i = $urandom;
        operand_B_i = $urandom;
        collect(lat);
        check("bp_second_latency", 64'(lat), 64'd4);
        check("bp_second_result", 64'(result_o), 64'h30);
        release_result(0);

        // Reset while cnt = 2: the operation must vanish.
        send(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0);
        @(posedge clk_i);
        @(negedge clk_i);
        @(posedge clk_i);
        @(negedge clk_i);
        rst_n_i = 1'b0;
        @(negedge clk_i);
        rst_n_i = 1'b1;
        check("midrst_ready", 64'(ready_o), 64'd1);
        check("midrst_valid", 64'(valid_o), 64'd0);
        check("midrst_result", 64'(result_o), 64'd0);
        repeat (6) @(negedge clk_i);
        check("midrst_no_report", 64'(valid_o), 64'd0);
        run_op("post_reset", 32'd3, 32'd4, 1'b0, 1'b0, 32'd7, 1'b0, 1'b0, 0);

        // Random regression: first half add, second half subtract.
        for (int i = 0; i < 1000; i++) begin
            ra = $urandom;
            rb = $urandom;
            if (i % 16 == 3)  ra = 32'h7FFF_FFFF;
            if (i % 16 == 7)  rb = 32'h8000_0000;
            if (i % 16 == 11) rb = ra;
            rs = (i >= 500);
            rc = 1'($urandom_range(0, 1));
            model(ra, rb, rs, rc, er, ec, eo);
            run_op($sformatf("rnd%0d", i), ra, rb, rs, rc, er, ec, eo, $urandom_range(0, 3));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/multiword_adder_sequencer.md
# multiword_adder_sequencer

Sequences a single narrow CHUNK_WIDTH adder over DATA_WIDTH-bit operands, one chunk per cycle, least significant chunk first, with the carry propagated through a register. It performs addition or two's-complement subtraction and produces result, carry and signed overflow. It sits between a requester using a valid/ready handshake and one shared chunk adder. The chunk adder has the standard adder port set: operand_A_i, operand_B_i, carry_i, result_o, carry_o.

## Interface

- DATA_WIDTH, 32, operand/result width; must be an integer multiple of CHUNK_WIDTH
- CHUNK_WIDTH, 8, width of the shared adder; N = DATA_WIDTH / CHUNK_WIDTH chunks per operation
- clk_i  input  1  single clock, all state updates on rising edge
- rst_n_i  input  1  reset, synchronous, active-low
- valid_i  input  1  request valid
- ready_o  output  1  sequencer can accept a request
- operand_A_i  input  DATA_WIDTH  first operand
- operand_B_i  input  DATA_WIDTH  second operand
- subtract_i  input  1  1 = A - B, 0 = A + B + carry_i
- carry_i  input  1  carry-in for addition; ignored when subtract_i = 1
- result_o  output  DATA_WIDTH  sum/difference
- carry_o  output  1  carry out of the MSB (for subtraction: 1 = no borrow)
- overflow_o  output  1  signed two's-complement overflow
- valid_o  output  1  result_o/carry_o/overflow_o valid
- ready_i  input  1  consumer accepts result

## Operation

- States: IDLE, COMPUTE, DONE.
- IDLE: ready_o = 1.
  - On valid_i && ready_o, capture:
    - A into the A register.
    - B, or ~B if subtract_i = 1, into the B register.
    - Carry register = subtract_i ? 1 : carry_i.
  - Chunk counter = 0; go to COMPUTE.
- COMPUTE: each cycle the shared adder takes:
  - A chunk [cnt*CHUNK_WIDTH +: CHUNK_WIDTH]
  - B chunk (already conditionally inverted), same index
  - carry register as carry-in
- COMPUTE update at each edge:
  - Chunk sum is written into result register chunk cnt.
  - Adder carry-out goes into the carry register.
  - cnt increments.
  - When cnt = N-1, go to DONE instead.
- Overflow is computed at the last chunk: overflow = (A[MSB] == B'[MSB]) && (sum[MSB] != A[MSB]), where B' is the inverted-or-not B.
- DONE: valid_o = 1; result_o, carry_o and overflow_o held stable. On ready_i go to IDLE; otherwise stay.
- ready_o = 1 only in IDLE. valid_i is ignored in COMPUTE and DONE. No acceptance happens in the same cycle as a DONE→IDLE transition.
- Operand registers are internal; input operands may change after acceptance without effect.
- result_o, carry_o and overflow_o keep their last values in IDLE but are only meaningful while valid_o = 1.
- N = 1 (CHUNK_WIDTH = DATA_WIDTH) is legal: COMPUTE lasts one cycle.

## Timing

- Reset (rst_n_i low at an edge):
  - State goes to IDLE; cnt = 0.
  - ready_o = 1; valid_o = 0.
  - result_o = 0, carry_o = 0, overflow_o = 0.
  - Applies from any state, including mid-COMPUTE and DONE. The in-flight operation is discarded, never reported.
- Latency: with acceptance at edge E0, chunks are processed at edges E1..EN. valid_o is high from just after EN.
- Minimum request period is N+2 cycles: accept, N compute, one DONE cycle with ready_i = 1.
- Carry chain: the carry out of chunk k is only visible to chunk k+1 through the register. There is no combinational path across chunks.
- ready_o and valid_o are decoded from registered state only; neither depends combinationally on valid_i or ready_i.

## Test plan

All tests use DATA_WIDTH = 32, CHUNK_WIDTH = 8 (N = 4).

- Add with full carry ripple: A = 0xFFFFFFFF, B = 0x00000001, carry_i = 0, subtract_i = 0.
  - result_o = 0x00000000, carry_o = 1, overflow_o = 0.
  - valid_o rises exactly 4 edges after acceptance.
- Subtract with borrow: A = 5, B = 7, subtract_i = 1.
  - result_o = 0xFFFFFFFE, carry_o = 0, overflow_o = 0.
  - Repeat with A = 7, B = 5: result_o = 2, carry_o = 1.
- Signed overflow:
  - A = 0x7FFFFFFF + B = 1 → result_o = 0x80000000, overflow_o = 1, carry_o = 0.
  - A = 0x80000000 - B = 1 → result_o = 0x7FFFFFFF, overflow_o = 1.
- Backpressure: hold ready_i = 0 for 3 cycles in DONE while driving valid_i = 1 with new operands.
  - valid_o stays 1, result unchanged, ready_o stays 0, new request not accepted.
  - ready_i = 1 → IDLE next cycle; the held request is accepted the cycle after.
- Reset mid-operation: assert rst_n_i = 0 for 1 cycle at cnt = 2.
  - Next cycle: ready_o = 1, valid_o = 0, result_o = 0.
  - A following request A = 3, B = 4 yields result_o = 7 with normal latency.
- Random regression: 1000 requests, first half add, second half subtract, ready_i randomly toggled.
  - Every {carry_o, result_o} matches the golden A + B + carry_i or A + ~B + 1.
  - Every overflow_o matches the golden signed check.
  - Zero mismatches reported.
